// File: rtl/bram_scrub_arbiter.sv
// Arbitrates the EBR port between the UART host and a fill/verify scrub sequencer.
// The host always wins; the sequencer writes a pattern everywhere, reads it back and counts mismatches.
module bram_scrub_arbiter #(
    parameter int NUM_BLOCKS = 30,
    localparam int NUM_BITS = $clog2(NUM_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            pattern_mode,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_count,
    output logic                  err_flag,
    output logic [NUM_BITS+7:0]   first_err_addr,
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic [NUM_BITS-1:0]   host_sel,
    input  logic [7:0]            host_addr,
    input  logic [15:0]           host_din,
    output logic                  host_gnt,
    output logic [NUM_BITS-1:0]   mem_select,
    output logic [7:0]            mem_addr,
    output logic [15:0]           mem_in,
    output logic                  rd_en,
    output logic                  wr_en,
    input  logic [15:0]           mem_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_LAST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state;
    logic [1:0]           mode_q;
    logic [NUM_BITS-1:0]  sel_q;
    logic [7:0]           addr_q;
    logic                 rd_pend;
    logic [15:0]          exp_data;
    logic [NUM_BITS+7:0]  exp_loc;
    logic                 last_loc;
    logic [15:0]          seq_pat;

    function automatic logic [15:0] pat(input logic [1:0] m,
                                        input logic [NUM_BITS-1:0] s,
                                        input logic [7:0] a);
        logic [15:0] p;
        case (m)
            2'd0:    p = 16'h0000;
            2'd1:    p = 16'hFFFF;
            2'd2:    p = {8'(s), a};
            default: p = (s[0] ^ a[0]) ? 16'hAAAA : 16'h5555;
        endcase
        return p;
    endfunction

    assign seq_pat  = pat(mode_q, sel_q, addr_q);
    assign last_loc = (sel_q == NUM_BITS'(NUM_BLOCKS - 1)) && (addr_q == 8'hFF);
    assign host_gnt = host_req;

    // The host takes the port whenever it asks; the sweep simply stalls that cycle.
    always_comb begin
        mem_select = '0;
        mem_addr   = '0;
        mem_in     = '0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        if (host_req) begin
            mem_select = host_sel;
            mem_addr   = host_addr;
            mem_in     = host_din;
            wr_en      = host_wr;
            rd_en      = ~host_wr;
        end else if (state == S_WRITE) begin
            mem_select = sel_q;
            mem_addr   = addr_q;
            mem_in     = seq_pat;
            wr_en      = 1'b1;
        end else if (state == S_READ) begin
            mem_select = sel_q;
            mem_addr   = addr_q;
            rd_en      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
            mode_q         <= '0;
            sel_q          <= '0;
            addr_q         <= '0;
            rd_pend        <= 1'b0;
            exp_data       <= '0;
            exp_loc        <= '0;
        end else begin
            done    <= 1'b0;
            rd_pend <= 1'b0;

            // mem_out answers the read issued last cycle, whatever the host does now.
            if (rd_pend && (mem_out != exp_data)) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (!err_flag) begin
                    err_flag       <= 1'b1;
                    first_err_addr <= exp_loc;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q         <= pattern_mode;
                        err_count      <= '0;
                        err_flag       <= 1'b0;
                        first_err_addr <= '0;
                        sel_q          <= '0;
                        addr_q         <= '0;
                        busy           <= 1'b1;
                        state          <= S_WRITE;
                    end
                end
                S_WRITE, S_READ: begin
                    if (!host_req) begin
                        if (state == S_READ) begin
                            rd_pend  <= 1'b1;
                            exp_data <= seq_pat;
                            exp_loc  <= {sel_q, addr_q};
                        end
                        if (last_loc) begin
                            sel_q  <= '0;
                            addr_q <= '0;
                            state  <= (state == S_WRITE) ? S_READ : S_LAST;
                        end else if (addr_q == 8'hFF) begin
                            addr_q <= '0;
                            sel_q  <= sel_q + 1'b1;
                        end else begin
                            addr_q <= addr_q + 8'd1;
                        end
                    end
                end
                S_LAST: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_scrub_arbiter.sv
// Bench for bram_scrub_arbiter with NUM_BLOCKS=2: idle mux vector table, then directed scrub runs.
module tb_bram_scrub_arbiter;

    localparam int NB = 2;
    localparam int NW = 512 * NB / 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  pattern_mode;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic        err_flag;
    logic [8:0]  first_err_addr;
    logic        host_req;
    logic        host_wr;
    logic        host_sel;
    logic [7:0]  host_addr;
    logic [15:0] host_din;
    logic        host_gnt;
    logic        mem_select;
    logic [7:0]  mem_addr;
    logic [15:0] mem_in;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] mem_out;

    int vectors = 0;
    int miscompares = 0;

    bram_scrub_arbiter #(.NUM_BLOCKS(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern_mode(pattern_mode),
        .busy(busy), .done(done), .err_count(err_count), .err_flag(err_flag),
        .first_err_addr(first_err_addr), .host_req(host_req), .host_wr(host_wr),
        .host_sel(host_sel), .host_addr(host_addr), .host_din(host_din),
        .host_gnt(host_gnt), .mem_select(mem_select), .mem_addr(mem_addr),
        .mem_in(mem_in), .rd_en(rd_en), .wr_en(wr_en), .mem_out(mem_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    // bram model: registered read, one-cycle latency
    logic [15:0] mem_arr [512];
    always @(posedge clk) begin
        if (wr_en) mem_arr[{mem_select, mem_addr}] <= mem_in;
        if (rd_en) mem_out <= mem_arr[{mem_select, mem_addr}];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] tb_pat(input logic [1:0] m, input int idx);
        case (m)
            2'd0: return 16'h0000;
            2'd1: return 16'hFFFF;
            2'd2: return idx[15:0];
            default: return (((idx >> 8) ^ idx) & 1) != 0 ? 16'hAAAA : 16'h5555;
        endcase
    endfunction

    // sequencer-operation monitor: order, addresses and write data of the sweep
    logic [1:0] mon_mode;
    int mon_wi, mon_ri, mon_bad;
    bit saw_0110, saw_wrap;
    always @(negedge clk) begin
        #2;
        if (!host_req && wr_en) begin
            if ({mem_select, mem_addr} != 9'(mon_wi) || mem_in != tb_pat(mon_mode, mon_wi))
                mon_bad++;
            if (mem_select == 1'b1 && mem_addr == 8'h10 && mem_in == 16'h0110) saw_0110 = 1;
            if (mon_wi == 256 && mem_select == 1'b1 && mem_addr == 8'h00) saw_wrap = 1;
            mon_wi++;
        end
        if (!host_req && rd_en) begin
            if ({mem_select, mem_addr} != 9'(mon_ri)) mon_bad++;
            mon_ri++;
        end
    end

    task automatic idle_inputs();
        start = 0; pattern_mode = 0; host_req = 0; host_wr = 0;
        host_sel = 0; host_addr = 0; host_din = 0;
    endtask

    // One scrub: start at cycle 0; optional host hold, host write, stray start, reset.
    task automatic run_scrub(input logic [1:0] mode, input int hold_at, input int hold_len,
                             input int hw_at, input int start_at, input int rst_at,
                             input int exp_lat);
        int done_cyc;
        logic hs;
        logic [7:0] ha;
        done_cyc = -1;
        mon_mode = mode; mon_wi = 0; mon_ri = 0; mon_bad = 0;
        saw_0110 = 0; saw_wrap = 0;
        for (int c = 0; c < 1300; c++) begin
            idle_inputs();
            pattern_mode = mode;
            start = (c == 0) || (c == start_at);
            reset = (c == rst_at);
            hs = 1'($urandom_range(0, 1));
            ha = 8'($urandom_range(0, 255));
            if (c >= hold_at && c < hold_at + hold_len) begin
                host_req = 1; host_wr = 0; host_sel = hs; host_addr = ha;
            end
            if (c == hw_at) begin
                host_req = 1; host_wr = 1; host_sel = 0; host_addr = 8'h05; host_din = 16'h1234;
            end
            #1;
            if (c >= hold_at && c < hold_at + hold_len)
                check("hold_mux", {host_gnt, rd_en, wr_en, mem_select, mem_addr},
                      {1'b1, 1'b1, 1'b0, hs, ha});
            if (c == 1) begin
                check("busy_run", busy, 1);
                check("err_cleared", {err_flag, first_err_addr, err_count}, 0);
            end
            if (rst_at >= 0 && c == rst_at + 1) check("busy_after_reset", busy, 0);
            if (done && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0) break;
            @(negedge clk);
        end
        idle_inputs();
        reset = 0;
        if (rst_at >= 0) begin
            check("no_done_after_reset", done_cyc, -1);
        end else begin
            check("done_latency", done_cyc, exp_lat);
            check("seq_write_count", mon_wi, NW);
            check("seq_read_count", mon_ri, NW);
            check("seq_order_data", mon_bad, 0);
            @(negedge clk); #1;
            check("done_pulse_idle", {done, busy}, 0);
        end
    endtask

    typedef struct {
        logic req, wr, sel;
        logic [7:0] addr;
        logic [15:0] din;
        logic [27:0] exp_mux;   // {gnt, rd_en, wr_en, mem_select, mem_addr, mem_in}
    } vec_t;
    vec_t tbl [6];

    initial begin
        tbl[0] = '{0, 0, 0, 8'h00, 16'h0000, {3'b000, 1'b0, 8'h00, 16'h0000}};
        tbl[1] = '{0, 1, 1, 8'hFF, 16'hBEEF, {3'b000, 1'b0, 8'h00, 16'h0000}};
        tbl[2] = '{1, 1, 1, 8'h3C, 16'hBEEF, {3'b101, 1'b1, 8'h3C, 16'hBEEF}};
        tbl[3] = '{1, 0, 0, 8'hA5, 16'h0000, {3'b110, 1'b0, 8'hA5, 16'h0000}};
        tbl[4] = '{1, 1, 0, 8'hFF, 16'hFFFF, {3'b101, 1'b0, 8'hFF, 16'hFFFF}};
        tbl[5] = '{1, 0, 1, 8'h01, 16'h5A5A, {3'b110, 1'b1, 8'h01, 16'h5A5A}};

        idle_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_status", {busy, done, err_flag, err_count, first_err_addr}, 0);
        check("reset_mux", {host_gnt, rd_en, wr_en, mem_select, mem_addr, mem_in}, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            host_req = tbl[i].req; host_wr = tbl[i].wr; host_sel = tbl[i].sel;
            host_addr = tbl[i].addr; host_din = tbl[i].din;
            #1;
            check($sformatf("idle_mux[%0d]", i),
                  {host_gnt, rd_en, wr_en, mem_select, mem_addr, mem_in}, tbl[i].exp_mux);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        run_scrub(2'd0, -100, 0, -1, -1, -1, 1026);
        check("m0_errors", {err_flag, err_count}, 0);

        run_scrub(2'd2, -100, 0, -1, -1, -1, 1026);
        check("m2_data_0110", saw_0110, 1);
        check("m2_sel_wrap", saw_wrap, 1);
        check("m2_errors", {err_flag, err_count}, 0);

        run_scrub(2'd3, -100, 0, -1, -1, -1, 1026);
        check("m3_errors", {err_flag, err_count}, 0);

        // host request in the start cycle does not block the start
        run_scrub(2'd1, 0, 1, -1, -1, -1, 1026);
        check("m1_errors", {err_flag, err_count}, 0);

        run_scrub(2'd0, 100, 10, -1, -1, -1, 1036);
        check("hold_errors", {err_flag, err_count}, 0);

        // host overwrite of (0,5) early in READ; its stall costs one cycle
        run_scrub(2'd0, -100, 0, 514, -1, -1, 1027);
        check("hw_err_count", err_count, 1);
        check("hw_err_flag", err_flag, 1);
        check("hw_first_err", first_err_addr, {1'b0, 8'h05});

        repeat (20) @(negedge clk);
        #1;
        check("results_hold", {err_flag, first_err_addr, err_count}, {1'b1, 9'h005, 16'd1});
        @(negedge clk);

        run_scrub(2'd0, -100, 0, -1, 50, -1, 1026);
        check("restart_clears", {err_flag, err_count}, 0);

        // reset during WRITE at addr 100 (cycle 101), then a fresh full run
        run_scrub(2'd0, -100, 0, -1, -1, 101, 0);
        @(negedge clk);
        run_scrub(2'd0, -100, 0, -1, -1, -1, 1026);
        check("post_reset_errors", {err_flag, err_count}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
